// File: rtl/interleaver_write_ctrl_if.sv
// -----------------------------------------------------------------------------
// interleaver_write_ctrl_if
// Bundles the serial input handshake, the RAM write port and the bank
// hand-off signals between the interleaver write controller and its
// neighbours (bit source, RAM, read controller).
//
// Signals:
//   data_in    serial input bit
//   valid_in   data_in valid
//   ready_in   controller can accept data_in this cycle
//   wraddress  RAM write address (ADDR_W bits)
//   wrdata     RAM write data
//   wren       RAM write enable
//   valid_out  a complete bank is available to the reader
//   rd_bank    bank the reader must consume (0=A, 1=B)
//   rd_release one-cycle pulse: current rd_bank fully read
//
// Modports:
//   master  the environment side (source, RAM, reader)
//   slave   the write controller
// -----------------------------------------------------------------------------
interface interleaver_write_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              data_in;
    logic              valid_in;
    logic              ready_in;
    logic [ADDR_W-1:0] wraddress;
    logic              wrdata;
    logic              wren;
    logic              valid_out;
    logic              rd_bank;
    logic              rd_release;

    modport master (
        output data_in, valid_in, rd_release,
        input  ready_in, wraddress, wrdata, wren, valid_out, rd_bank
    );

    modport slave (
        input  data_in, valid_in, rd_release,
        output ready_in, wraddress, wrdata, wren, valid_out, rd_bank
    );
endinterface

// File: rtl/interleaver_write_ctrl.sv
// -----------------------------------------------------------------------------
// interleaver_write_ctrl
// Write side of the ping-pong interleaver buffer. Serial bits accepted over a
// valid/ready handshake are written into a 2*BLOCK_SIZE dual-port RAM, bank A
// at 0..BLOCK_SIZE-1 and bank B at BLOCK_SIZE..2*BLOCK_SIZE-1. Completed banks
// are published to the read controller, which hands them back with rd_release.
//
// Ports:
//   clk     single clock, rising edge
//   resetN  asynchronous, active-low reset
//   bus     interleaver_write_ctrl_if.slave (handshake, RAM port, bank hand-off)
//
// Parameters:
//   BLOCK_SIZE  entries per bank
//   ADDR_W      RAM address width, 2*BLOCK_SIZE <= 2**ADDR_W
// -----------------------------------------------------------------------------
module interleaver_write_ctrl #(
    parameter int BLOCK_SIZE = 192,
    parameter int ADDR_W     = 9
) (
    input  logic                     clk,
    input  logic                     resetN,
    interleaver_write_ctrl_if.slave  bus
);

    localparam int PTR_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(BLOCK_SIZE - 1);
    localparam logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(BLOCK_SIZE);

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              full_pend;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              data_q;
    logic              wren_q;

    logic              ready;
    logic              accept;
    logic              last_bit;
    logic              release_ok;
    logic [ADDR_W-1:0] wr_addr;

    assign ready      = (state == FILL);
    assign accept     = bus.valid_in && ready;
    assign last_bit   = accept && (wr_ptr == LAST_PTR);
    // A release only counts once the reader has actually been told the bank is valid.
    assign release_ok = bus.rd_release && valid_q;
    assign wr_addr    = (wr_bank ? BANK_BASE : '0) + ADDR_W'(wr_ptr);

    assign bus.ready_in  = ready;
    assign bus.wraddress = addr_q;
    assign bus.wrdata    = data_q;
    assign bus.wren      = wren_q;
    assign bus.valid_out = valid_q;
    assign bus.rd_bank   = rd_bank;

    // Bank occupancy after this edge. The release is applied first so that a
    // block completing on the same edge sees the bank the reader just freed.
    // The FSM stalls only when the bank we are about to write into is still full.
    always_comb begin
        full_next  = full;
        state_next = state;
        if (release_ok) begin
            full_next[rd_bank] = 1'b0;
        end
        if (last_bit) begin
            full_next[wr_bank] = 1'b1;
        end
        case (state)
            FILL: begin
                if (last_bit && full_next[~wr_bank]) begin
                    state_next = STALL;
                end
            end
            STALL: begin
                if (!full_next[wr_bank]) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // State, occupancy and the write pointer / bank selection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= FILL;
            full    <= 2'b00;
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
        end else begin
            state <= state_next;
            full  <= full_next;
            if (accept) begin
                if (last_bit) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Registered RAM write port; address and data hold when nothing is accepted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= 1'b0;
        end else begin
            wren_q <= accept;
            if (accept) begin
                addr_q <= wr_addr;
                data_q <= bus.data_in;
            end
        end
    end

    // valid_out trails full[rd_bank] by two registers so the RAM write of the
    // last bit lands before the reader is told. A release flushes both stages,
    // otherwise the stale flag of the old bank would leak through one cycle later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_bank   <= 1'b0;
            full_pend <= 1'b0;
            valid_q   <= 1'b0;
        end else if (release_ok) begin
            rd_bank   <= ~rd_bank;
            full_pend <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            full_pend <= full[rd_bank];
            valid_q   <= full_pend;
        end
    end

endmodule

// File: tb/tb_interleaver_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interleaver_write_ctrl
// Directed bench for interleaver_write_ctrl: a table of per-cycle vectors
// (inputs plus hand-derived outputs after the edge) covering two bank fills,
// stall, release in stall, same-edge release/completion and ignored releases,
// followed by a hand-written mid-block reset sequence.
// -----------------------------------------------------------------------------
module tb_interleaver_write_ctrl;

    localparam int BLOCK_SIZE = 192;
    localparam int ADDR_W     = 9;

    typedef struct {
        logic              valid;
        logic              data;
        logic              rel;
        logic              exp_wren;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_wrdata;
        logic              exp_ready;
        logic              exp_valid_out;
        logic              exp_rd_bank;
    } vec_t;

    logic clk;
    logic resetN;
    int   checks;
    int   failures;
    vec_t vec_table[$];

    interleaver_write_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    interleaver_write_ctrl #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stops advancing.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_vec(input logic valid, input logic data, input logic rel,
                           input logic wren, input int addr, input logic wrdata,
                           input logic ready, input logic vo, input logic rb);
        vec_t v;
        v.valid         = valid;
        v.data          = data;
        v.rel           = rel;
        v.exp_wren      = wren;
        v.exp_addr      = ADDR_W'(addr);
        v.exp_wrdata    = wrdata;
        v.exp_ready     = ready;
        v.exp_valid_out = vo;
        v.exp_rd_bank   = rb;
        vec_table.push_back(v);
    endtask

    task automatic check_output(input string name, input int idx,
                                input logic [ADDR_W-1:0] actual,
                                input logic [ADDR_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s vec=%0d got=%0d expected=%0d", name, idx, actual, expected);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check_output("wren",      idx, ADDR_W'(bus.wren),      ADDR_W'(v.exp_wren));
        check_output("wraddress", idx, bus.wraddress,          v.exp_addr);
        check_output("wrdata",    idx, ADDR_W'(bus.wrdata),    ADDR_W'(v.exp_wrdata));
        check_output("ready_in",  idx, ADDR_W'(bus.ready_in),  ADDR_W'(v.exp_ready));
        check_output("valid_out", idx, ADDR_W'(bus.valid_out), ADDR_W'(v.exp_valid_out));
        check_output("rd_bank",   idx, ADDR_W'(bus.rd_bank),   ADDR_W'(v.exp_rd_bank));
    endtask

    // Drive one cycle of inputs, clock it in, then sample just after the edge.
    task automatic apply_stimulus(input int idx, input vec_t v);
        bus.valid_in   = v.valid;
        bus.data_in    = v.data;
        bus.rd_release = v.rel;
        @(posedge clk);
        #1;
        check_all(idx, v);
    endtask

    initial begin
        vec_t v;
        checks         = 0;
        failures       = 0;
        resetN         = 1'b0;
        bus.valid_in   = 1'b0;
        bus.data_in    = 1'b0;
        bus.rd_release = 1'b0;

        // Bank A fill: addresses 0..191, nothing published yet.
        for (int p = 0; p < BLOCK_SIZE; p++)
            add_vec(1'b1, 1'(p % 2), 1'b0, 1'b1, p, 1'(p % 2), 1'b1, 1'b0, 1'b0);
        // Bank B fill: A becomes visible two edges after its last bit; stall after B completes.
        for (int p = 0; p < BLOCK_SIZE; p++)
            add_vec(1'b1, 1'(p % 2), 1'b0, 1'b1, BLOCK_SIZE + p, 1'(p % 2),
                    1'(p != BLOCK_SIZE - 1), 1'(p >= 1), 1'b0);
        // Stalled: valid_in ignored, write port holds at 383 / 1.
        for (int k = 0; k < 3; k++)
            add_vec(1'b1, 1'b0, 1'b0, 1'b0, 383, 1'b1, 1'b0, 1'b1, 1'b0);
        // Release A while stalled: valid_out drops, rd_bank->B, ready back.
        add_vec(1'b1, 1'b0, 1'b1, 1'b0, 383, 1'b1, 1'b1, 1'b0, 1'b1);
        // Refill A; B shows up again two edges after the release. Release B mid-fill.
        for (int p = 0; p < BLOCK_SIZE; p++)
            add_vec(1'b1, 1'(p % 2), 1'(p == 100), 1'b1, p, 1'(p % 2), 1'b1,
                    1'(p >= 1 && p < 100), 1'(p < 100));
        // Fill B; release A on the same edge as B's last bit, no stall follows.
        for (int p = 0; p < BLOCK_SIZE; p++)
            add_vec(1'b1, 1'(p % 2), 1'(p == BLOCK_SIZE - 1), 1'b1, BLOCK_SIZE + p, 1'(p % 2),
                    1'b1, 1'(p >= 1 && p < BLOCK_SIZE - 1), 1'(p == BLOCK_SIZE - 1));
        // Writes restart at address 0 of A; B published two edges after the release.
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        add_vec(1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1);
        // Gaps in valid_in and releases while valid_out=0 (second and fifth are ignored).
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        // Continue A up to its 100th bit ahead of the reset test.
        for (int p = 4; p < 100; p++)
            add_vec(1'b1, 1'(p % 2), 1'b0, 1'b1, p, 1'(p % 2), 1'b1, 1'b0, 1'b0);

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        v = '{valid: 1'b0, data: 1'b0, rel: 1'b0, exp_wren: 1'b0, exp_addr: '0,
              exp_wrdata: 1'b0, exp_ready: 1'b1, exp_valid_out: 1'b0, exp_rd_bank: 1'b0};
        check_all(-1, v);
        @(negedge clk);
        resetN = 1'b1;

        for (int i = 0; i < vec_table.size(); i++)
            apply_stimulus(i, vec_table[i]);

        // Asynchronous reset mid-block: outputs clear without waiting for an edge.
        #3;
        resetN = 1'b0;
        #1;
        check_all(-2, v);
        bus.valid_in = 1'b1;
        @(negedge clk);
        resetN = 1'b1;

        // Fresh block after reset starts at address 0; nothing published until it completes.
        for (int p = 0; p < BLOCK_SIZE; p++) begin
            v = '{valid: 1'b1, data: 1'(p % 2), rel: 1'b0, exp_wren: 1'b1, exp_addr: ADDR_W'(p),
                  exp_wrdata: 1'(p % 2), exp_ready: 1'b1, exp_valid_out: 1'b0, exp_rd_bank: 1'b0};
            apply_stimulus(1000 + p, v);
        end
        v = '{valid: 1'b0, data: 1'b0, rel: 1'b0, exp_wren: 1'b0, exp_addr: ADDR_W'(191),
              exp_wrdata: 1'b1, exp_ready: 1'b1, exp_valid_out: 1'b0, exp_rd_bank: 1'b0};
        apply_stimulus(2000, v);
        v.exp_valid_out = 1'b1;
        apply_stimulus(2001, v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
